// File: rtl/spdot_pkg.sv
// Shared types and constants for the spdot loader/core pair.
// Holds the loader state encoding, default geometry and a saturating counter helper.
package spdot_pkg;

    localparam int SPDOT_DW     = 32;
    localparam int SPDOT_DEPTH  = 256;
    localparam int SPDOT_AW     = 8;
    localparam int SPDOT_HD_MAX = SPDOT_DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_Q    = 3'd1,
        ST_LOAD_K    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_CORE = 3'd4
    } loader_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = 16'hFFFF;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spdot_spm_loader_if.sv
// Valid/ready word stream feeding the loader scratchpads.
// master drives words, slave (the loader) returns ready.
interface spdot_spm_loader_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/spdot_spm_bank.sv
// Single-write, async-read scratchpad bank; addresses beyond DEPTH read as zero.
// Contents are intentionally not reset.
module spdot_spm_bank #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [15:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port: one word per cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: the core registers its address, so data must be available same cycle.
    always_comb begin
        rdata = '0;
        if (raddr[15:AW] != '0) begin
            rdata = '0;
        end else begin
            rdata = mem_r[raddr[AW-1:0]];
        end
    end

endmodule

// File: rtl/spdot_spm_loader.sv
// Loads one Q and one K vector from a word stream into two scratchpads,
// kicks the spdot core and keeps the buffers frozen until it reports done.
module spdot_spm_loader
    import spdot_pkg::*;
#(
    parameter int DW    = SPDOT_DW,
    parameter int DEPTH = SPDOT_HD_MAX,
    parameter int AW    = SPDOT_AW
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_start,
    input  logic [15:0]         head_dim_d,
    spdot_spm_loader_if.slave   stream,
    input  logic [15:0]         q_raddr,
    output logic [DW-1:0]       q_rdata,
    input  logic [15:0]         k_raddr,
    output logic [DW-1:0]       k_rdata,
    output logic                core_start,
    input  logic                core_done,
    output logic                busy,
    output logic                err,
    output logic [15:0]         words_loaded
);

    loader_state_e state_r;
    logic          in_ready_r;
    logic          core_start_r;
    logic          busy_r;
    logic          err_r;
    logic [15:0]   words_loaded_r;
    logic [15:0]   hd_q_r;
    logic [15:0]   idx_r;

    logic          accept_s;
    logic          last_idx_s;
    logic          hd_bad_s;
    logic          q_we_s;
    logic          k_we_s;

    // Handshake qualification and end-of-vector detection.
    always_comb begin
        accept_s   = 1'b0;
        last_idx_s = 1'b0;
        hd_bad_s   = 1'b0;
        q_we_s     = 1'b0;
        k_we_s     = 1'b0;
        accept_s   = stream.in_valid && in_ready_r;
        last_idx_s = (idx_r == (hd_q_r - 16'd1));
        hd_bad_s   = (head_dim_d == 16'd0) || (head_dim_d > 16'(DEPTH));
        q_we_s     = accept_s && (state_r == ST_LOAD_Q);
        k_we_s     = accept_s && (state_r == ST_LOAD_K);
    end

    // Transaction sequencer; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= ST_IDLE;
            in_ready_r     <= 1'b0;
            core_start_r   <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
            words_loaded_r <= 16'd0;
            hd_q_r         <= 16'd0;
            idx_r          <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_start) begin
                        hd_q_r         <= head_dim_d;
                        words_loaded_r <= 16'd0;
                        idx_r          <= 16'd0;
                        if (hd_bad_s) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r      <= 1'b0;
                            state_r    <= ST_LOAD_Q;
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                ST_LOAD_Q: begin
                    if (accept_s) begin
                        words_loaded_r <= sat_inc16(words_loaded_r);
                        if (stream.in_last) begin
                            err_r      <= 1'b1;
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            idx_r      <= 16'd0;
                        end else if (last_idx_s) begin
                            idx_r   <= 16'd0;
                            state_r <= ST_LOAD_K;
                        end else begin
                            idx_r <= idx_r + 16'd1;
                        end
                    end
                end
                ST_LOAD_K: begin
                    if (accept_s) begin
                        words_loaded_r <= sat_inc16(words_loaded_r);
                        // A missing in_last on the final word is flagged but the core still runs.
                        if (last_idx_s) begin
                            if (!stream.in_last) begin
                                err_r <= 1'b1;
                            end
                            idx_r        <= 16'd0;
                            state_r      <= ST_START;
                            in_ready_r   <= 1'b0;
                            core_start_r <= 1'b1;
                        end else if (stream.in_last) begin
                            err_r      <= 1'b1;
                            state_r    <= ST_IDLE;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            idx_r      <= 16'd0;
                        end else begin
                            idx_r <= idx_r + 16'd1;
                        end
                    end
                end
                ST_START: begin
                    core_start_r <= 1'b0;
                    state_r      <= ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    if (core_done) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    in_ready_r   <= 1'b0;
                    core_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    spdot_spm_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_q_bank (
        .clk   (clk),
        .we    (q_we_s),
        .waddr (idx_r[AW-1:0]),
        .wdata (stream.in_data),
        .raddr (q_raddr),
        .rdata (q_rdata)
    );

    spdot_spm_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_k_bank (
        .clk   (clk),
        .we    (k_we_s),
        .waddr (idx_r[AW-1:0]),
        .wdata (stream.in_data),
        .raddr (k_raddr),
        .rdata (k_rdata)
    );

    assign stream.in_ready = in_ready_r;
    assign core_start      = core_start_r;
    assign busy            = busy_r;
    assign err             = err_r;
    assign words_loaded    = words_loaded_r;

endmodule

// File: tb/tb_spdot_spm_loader.sv
// Bench for spdot_spm_loader: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_spdot_spm_loader;
    import spdot_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] head_dim_d = 16'd0;
    logic [15:0] q_raddr = 16'd0;
    logic [15:0] k_raddr = 16'd0;
    logic [31:0] q_rdata;
    logic [31:0] k_rdata;
    logic        core_start;
    logic        core_done = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;

    spdot_spm_loader_if #(.DW(32)) s_if ();

    spdot_spm_loader dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_start    (cfg_start),
        .head_dim_d   (head_dim_d),
        .stream       (s_if.slave),
        .q_raddr      (q_raddr),
        .q_rdata      (q_rdata),
        .k_raddr      (k_raddr),
        .k_rdata      (k_rdata),
        .core_start   (core_start),
        .core_done    (core_done),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction model: word count drives everything.
    logic        m_active = 1'b0;
    logic        m_start  = 1'b0;
    logic        m_wait   = 1'b0;
    logic        m_err    = 1'b0;
    int          m_cnt    = 0;
    int          m_hd     = 0;
    logic [31:0] q_m [256];
    logic [31:0] k_m [256];
    logic        q_def [256];
    logic        k_def [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            q_def[i] = 1'b0;
            k_def[i] = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on every clock edge (inputs are stable well before it).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 1'b0;
            m_start  = 1'b0;
            m_wait   = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 0;
            m_hd     = 0;
        end else if (m_start) begin
            m_start = 1'b0;
            m_wait  = 1'b1;
        end else if (m_wait) begin
            if (core_done) m_wait = 1'b0;
        end else if (m_active) begin
            if (s_if.in_valid) begin
                if (m_cnt < m_hd) begin
                    q_m[m_cnt] = s_if.in_data;
                    q_def[m_cnt] = 1'b1;
                end else begin
                    k_m[m_cnt - m_hd] = s_if.in_data;
                    k_def[m_cnt - m_hd] = 1'b1;
                end
                m_cnt++;
                if (m_cnt == 2 * m_hd) begin
                    m_active = 1'b0;
                    m_start  = 1'b1;
                    if (!s_if.in_last) m_err = 1'b1;
                end else if (s_if.in_last) begin
                    m_active = 1'b0;
                    m_err    = 1'b1;
                end
            end
        end else if (cfg_start) begin
            m_hd  = int'(head_dim_d);
            m_cnt = 0;
            m_err = 1'b0;
            if (m_hd == 0 || m_hd > 256) m_err = 1'b1;
            else m_active = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("in_ready", {31'd0, s_if.in_ready}, {31'd0, m_active});
        check("core_start", {31'd0, core_start}, {31'd0, m_start});
        check("busy", {31'd0, busy}, {31'd0, (m_active | m_start | m_wait)});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("words_loaded", {16'd0, words_loaded}, (m_cnt > 65535) ? 32'hFFFF : m_cnt);
        if (q_raddr >= 16'd256) check("q_rdata_oor", q_rdata, 32'd0);
        else if (q_def[q_raddr[7:0]]) check("q_rdata", q_rdata, q_m[q_raddr[7:0]]);
        if (k_raddr >= 16'd256) check("k_rdata_oor", k_rdata, 32'd0);
        else if (k_def[k_raddr[7:0]]) check("k_rdata", k_rdata, k_m[k_raddr[7:0]]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] hd);
        cfg_start  = 1'b1;
        head_dim_d = hd;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        logic rdy;
        logic ok;
        ok = 1'b0;
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        s_if.in_last  = last;
        for (int t = 0; t < 50; t++) begin
            rdy = s_if.in_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_timeout: got no ready expected ready for word %0h", d);
        end
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
    endtask

    task automatic done_pulse();
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic load4(input logic [31:0] base, input logic tag_last);
        cfg(16'd4);
        for (int i = 0; i < 8; i++) send_word(base + 32'(i), (i == 7) ? tag_last : 1'b0);
    endtask

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_data  = 32'd0;
        s_if.in_last  = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, s_if.in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        step();
        rstn = 1'b1;
        step();

        // Back-to-back load of hd=4.
        load4(32'd1, 1'b1);
        @(negedge clk);
        check("t1_core_start", {31'd0, core_start}, 32'd1);
        check("t1_words", {16'd0, words_loaded}, 32'd8);
        check("t1_err", {31'd0, err}, 32'd0);
        step();
        q_raddr = 16'd2;
        k_raddr = 16'd3;
        @(negedge clk);
        check("t1_q2", q_rdata, 32'd3);
        check("t1_k3", k_rdata, 32'd8);
        check("t1_start_drop", {31'd0, core_start}, 32'd0);
        check("t1_ready_wait", {31'd0, s_if.in_ready}, 32'd0);
        done_pulse();
        @(negedge clk);
        check("t1_busy_done", {31'd0, busy}, 32'd0);

        // Gappy load, final word without in_last.
        cfg(16'd4);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send_word(32'd1 + 32'(i), 1'b0);
        end
        @(negedge clk);
        check("t2_core_start", {31'd0, core_start}, 32'd1);
        check("t2_err_nolast", {31'd0, err}, 32'd1);
        repeat (3) step();
        for (int a = 0; a < 4; a++) begin
            q_raddr = 16'(a);
            k_raddr = 16'(a);
            step();
        end
        @(negedge clk);
        check("t2_k3", k_rdata, 32'd8);
        check("t2_busy_wait", {31'd0, busy}, 32'd1);
        done_pulse();
        @(negedge clk);
        check("t2_busy_done", {31'd0, busy}, 32'd0);

        // Illegal lengths.
        cfg(16'd0);
        @(negedge clk);
        check("t3_err_hd0", {31'd0, err}, 32'd1);
        check("t3_ready_hd0", {31'd0, s_if.in_ready}, 32'd0);
        cfg(16'd257);
        @(negedge clk);
        check("t3_err_hd257", {31'd0, err}, 32'd1);
        check("t3_busy_hd257", {31'd0, busy}, 32'd0);

        // Early in_last on the third word.
        cfg(16'd4);
        @(negedge clk);
        check("t4_err_clear", {31'd0, err}, 32'd0);
        send_word(32'd21, 1'b0);
        send_word(32'd22, 1'b0);
        send_word(32'd23, 1'b1);
        @(negedge clk);
        check("t4_err_early", {31'd0, err}, 32'd1);
        check("t4_busy_early", {31'd0, busy}, 32'd0);
        check("t4_words_early", {16'd0, words_loaded}, 32'd3);
        load4(32'd31, 1'b1);
        @(negedge clk);
        check("t4_err_cleared", {31'd0, err}, 32'd0);
        done_pulse();

        // Full-depth load, cfg_start ignored while waiting on the core.
        cfg(16'd256);
        for (int i = 0; i < 256; i++) send_word(32'd100 + 32'(i), 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'd1000 + 32'(i), (i == 255) ? 1'b1 : 1'b0);
        @(negedge clk);
        check("t5_words", {16'd0, words_loaded}, 32'd512);
        step();
        cfg(16'd4);
        @(negedge clk);
        check("t5_busy_ignore", {31'd0, busy}, 32'd1);
        check("t5_words_ignore", {16'd0, words_loaded}, 32'd512);
        for (int a = 0; a < 256; a++) begin
            q_raddr = 16'(a);
            k_raddr = 16'(255 - a);
            step();
        end
        k_raddr = 16'd255;
        q_raddr = 16'hFFFF;
        @(negedge clk);
        check("t5_k255", k_rdata, 32'd1255);
        check("t5_q_ffff", q_rdata, 32'd0);
        step();
        k_raddr = 16'd256;
        @(negedge clk);
        check("t5_k256", k_rdata, 32'd0);
        done_pulse();

        // Reset asserted mid LOAD_K, then a clean transaction.
        cfg(16'd4);
        for (int i = 0; i < 5; i++) send_word(32'd61 + 32'(i), 1'b0);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 32'd66;
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rst_ready", {31'd0, s_if.in_ready}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_words", {16'd0, words_loaded}, 32'd0);
        check("t6_rst_start", {31'd0, core_start}, 32'd0);
        step();
        s_if.in_valid = 1'b0;
        rstn = 1'b1;
        step();
        load4(32'd41, 1'b1);
        q_raddr = 16'd0;
        k_raddr = 16'd0;
        @(negedge clk);
        check("t6_core_start", {31'd0, core_start}, 32'd1);
        check("t6_q0", q_rdata, 32'd41);
        check("t6_k0", k_rdata, 32'd45);
        done_pulse();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
